// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Reset sequencer for the io router SDR link: holds all link resets, pulses the token
// reset, then releases uplink, downlink and downstream in order, one step at a time.
module bsg_link_sdr_reset_sequencer #(
    parameter int unsigned step_cycles_p = 16
) (
    input  logic core_clk_i,
    input  logic core_reset_n_i,
    input  logic start_i,
    output logic async_uplink_reset_o,
    output logic async_downlink_reset_o,
    output logic async_downstream_reset_o,
    output logic async_token_reset_o,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned lg_step_lp = (step_cycles_p <= 2) ? 1 : $clog2(step_cycles_p);
    localparam logic [lg_step_lp-1:0] step_max_lp = lg_step_lp'(step_cycles_p - 1);

    typedef enum logic [2:0] {
        StAssert,
        StTokenHi,
        StTokenLo,
        StUpRel,
        StDownRel,
        StDsRel,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [lg_step_lp-1:0] cnt_q, cnt_d;
    logic                  up_q, up_d;
    logic                  down_q, down_d;
    logic                  ds_q, ds_d;
    logic                  tok_q, tok_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            state_d = StAssert;
            cnt_d   = '0;
        end else if (state_q == StDone) begin
            cnt_d = '0;
        end else if (cnt_q == step_max_lp) begin
            cnt_d = '0;
            case (state_q)
                StAssert:  state_d = StTokenHi;
                StTokenHi: state_d = StTokenLo;
                StTokenLo: state_d = StUpRel;
                StUpRel:   state_d = StDownRel;
                StDownRel: state_d = StDsRel;
                StDsRel:   state_d = StDone;
                default:   state_d = StAssert;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs decode the next state so the flops feeding other clock domains switch
    // on the same edge as the state register.
    always_comb begin
        {up_d, down_d, ds_d, tok_d} = 4'b1110;
        case (state_d)
            StAssert:  {up_d, down_d, ds_d, tok_d} = 4'b1110;
            StTokenHi: {up_d, down_d, ds_d, tok_d} = 4'b1111;
            StTokenLo: {up_d, down_d, ds_d, tok_d} = 4'b1110;
            StUpRel:   {up_d, down_d, ds_d, tok_d} = 4'b0110;
            StDownRel: {up_d, down_d, ds_d, tok_d} = 4'b0010;
            StDsRel:   {up_d, down_d, ds_d, tok_d} = 4'b0000;
            StDone:    {up_d, down_d, ds_d, tok_d} = 4'b0000;
            default:   {up_d, down_d, ds_d, tok_d} = 4'b1110;
        endcase
        busy_d = (state_d != StDone);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            state_q <= StAssert;
            cnt_q   <= '0;
            up_q    <= 1'b1;
            down_q  <= 1'b1;
            ds_q    <= 1'b1;
            tok_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            down_q  <= down_d;
            ds_q    <= ds_d;
            tok_q   <= tok_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign async_uplink_reset_o     = up_q;
    assign async_downlink_reset_o   = down_q;
    assign async_downstream_reset_o = ds_q;
    assign async_token_reset_o      = tok_q;
    assign busy_o                   = busy_q;
    assign done_o                   = done_q;

endmodule
